fifo_pixel_streamer: RTL
========================

// Module: fifo_pixel_streamer
// PURPOSE
//  Read side of the filter's line/pixel sync FIFO: pops show-ahead FIFO words and emits a
//  valid/ready pixel stream tagged with sof/eol/eof for one H_ACTIVE x V_ACTIVE frame per
//  frame_start. Sits between the pixel sync FIFO and the downstream bilateral filter window.
//  Provides full-throughput draining under backpressure, and counts FIFO underrun cycles.
// PARAMETERS
//  DATA_W    8    pixel width; equals FIFO word width
//  H_ACTIVE  640  pixels per line (>=1)
//  V_ACTIVE  480  lines per frame (>=1)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset: synchronous, active-low
//  frame_start  in   1       one-cycle arm pulse; ignored while busy=1
//  fifo_empty   in   1       FIFO empty flag
//  fifo_dout    in   DATA_W  FIFO head word (show-ahead: valid while fifo_empty=0)
//  fifo_rd_en   out  1       pop request (combinational)
//  m_valid      out  1       stream beat valid
//  m_ready      in   1       downstream accept
//  m_data       out  DATA_W  pixel
//  m_sof        out  1       first pixel of frame (x=0,y=0)
//  m_eol        out  1       last pixel of line (x=H_ACTIVE-1)
//  m_eof        out  1       last pixel of frame
//  busy         out  1       frame in progress (state!=IDLE)
//  frame_done   out  1       one-cycle pulse, frame fully delivered
//  underrun_cnt out  16      underrun cycles this frame, saturating
// BEHAVIOUR
//  Reset: state=IDLE, x/y=0, buffer count=0; m_valid, m_data, m_sof/eol/eof, busy,
//   frame_done, underrun_cnt, fifo_rd_en all 0. FIFO contents untouched (owner flushes).
//  FSM: IDLE -frame_start-> STREAM -last pixel popped-> DRAIN -buffer empty-> IDLE.
//   frame_done=1 for exactly the cycle DRAIN->IDLE; this is the cycle after the eof handshake.
//  Pop rule: fifo_rd_en = (state==STREAM) & !fifo_empty & (cnt<2). Never high when
//   fifo_empty=1, in IDLE/DRAIN, or with buffer full.
//  Tagging at pop: {eof,eol,sof,fifo_dout} written into 2-entry output buffer; sof when
//   x==0&&y==0, eol when x==H_ACTIVE-1, eof when eol && y==V_ACTIVE-1. x wraps to 0 on eol,
//   y increments; on eof x,y clear. Counters width clog2(H_ACTIVE)/clog2(V_ACTIVE), min 1.
//  Latency: pop in cycle N -> beat on m_* in cycle N+1 (registered output). Steady
//   m_ready=1 with non-empty FIFO gives one beat per cycle, cnt stays 1.
//  Handshake: transfer on m_valid&m_ready. While m_valid&!m_ready, m_data and tags hold stable.
//   m_valid never deasserts without a transfer. Output buffer order strictly FIFO; pop and
//   transfer in the same cycle leave cnt unchanged.
//  Underrun: +1 per cycle with state==STREAM & fifo_empty & cnt<2; saturates at 16'hFFFF;
//   cleared to 0 on accepted frame_start; holds value after frame until next start.
//  frame_start while busy=1 ignored (no counter/state effect). Reset mid-frame returns to
//   reset state in one cycle; next accepted frame_start restarts at x=y=0 with sof.
//  H_ACTIVE=1: every beat has eol. H_ACTIVE=V_ACTIVE=1: single beat carries sof,eol,eof.
// STRUCTURE
//  Shared package: FSM state localparams (IDLE/STREAM/DRAIN), clog2 function,
//   tag bit positions {EOF,EOL,SOF} in buffer word.
//  Sub-module: stream_skid_buf (2-entry valid/ready buffer, WIDTH=DATA_W+3, exposes cnt);
//   top holds FSM, x/y counters, pop logic, underrun counter.
// TESTING  (H_ACTIVE=4, V_ACTIVE=2 unless noted)
//  1 Reset held 3 cycles with random inputs -> every output 0; fifo_rd_en 0 throughout.
//  2 FIFO preloaded 0x10..0x17, m_ready=1, frame_start @N -> 8 beats 0x10..0x17 on N+2..N+9,
//    sof on 0x10, eol on 0x13/0x17, eof on 0x17, frame_done @N+10, underrun_cnt=0.
//  3 Same data, m_ready pattern 1,0,1,0... -> identical sequence, no loss/dup, m_data stable
//    while stalled, fifo_rd_en never high with 2 entries held.
//  4 FIFO empty 5 cycles after 0x12 popped, then refilled -> m_valid gap, order preserved,
//    underrun_cnt=5 at frame_done; new frame_start clears it to 0.
//  5 frame_start pulsed mid-frame -> ignored, still exactly 8 beats; rst_n=0 after 3rd beat ->
//    all outputs 0 next cycle; next frame_start gives sof on next FIFO word.
//  6 H_ACTIVE=1,V_ACTIVE=1, word 0xAB -> one beat 0xAB with sof=eol=eof=1, frame_done next cycle.

Source files
------------

// File: rtl/fifo_pixel_streamer_pkg.sv
// Shared definitions for the pixel streamer: FSM state codes, tag bit
// offsets inside the output buffer word, and a width helper.
package fifo_pixel_streamer_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Buffer word layout is {eof, eol, sof, data}; these are offsets above DATA_W
    localparam int TAG_SOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 2;
    localparam int TAG_W   = 3;

    // Ceiling log2 with a floor of 1 so a 1-pixel dimension still gets a counter bit
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry registered valid/ready buffer. Head entry drives the output
// directly, so data is registered and stays stable while stalled. The
// writer must only push when cnt < 2 or when a pop happens in the same cycle.
module stream_skid_buf #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign push      = in_valid;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_q;
    assign cnt       = cnt_q;

    // Occupancy and entry update: strict FIFO order, head always oldest
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the storage registers are reset too because the head entry is
            // a visible output (m_data) that must read 0 out of reset.
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pixel_streamer.sv
// Read side of the line/pixel sync FIFO. Pops show-ahead words while a frame
// is in progress, tags each with sof/eol/eof from its raster position, and
// streams them out through a two-entry registered buffer. Also counts cycles
// the stream starved on an empty FIFO.
module fifo_pixel_streamer
    import fifo_pixel_streamer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       underrun_cnt
);

    localparam int XW    = clog2_min1(H_ACTIVE);
    localparam int YW    = clog2_min1(V_ACTIVE);
    localparam int BUF_W = DATA_W + TAG_W;

    logic [1:0]       state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [15:0]      under_q;
    logic [1:0]       buf_cnt;
    logic [BUF_W-1:0] pop_word;
    logic [BUF_W-1:0] buf_word;
    logic             tag_sof;
    logic             tag_eol;
    logic             tag_eof;
    logic             underrun_cycle;

    assign tag_sof = (x_q == '0) && (y_q == '0);
    assign tag_eol = (x_q == XW'(H_ACTIVE - 1));
    assign tag_eof = tag_eol && (y_q == YW'(V_ACTIVE - 1));

    // Gated by rst_n so no pop can escape while reset is held, even in the
    // very first cycle before the state register has been cleared.
    assign fifo_rd_en = rst_n & (state_q == ST_STREAM) & ~fifo_empty & (buf_cnt < 2'd2);

    assign underrun_cycle = (state_q == ST_STREAM) & fifo_empty & (buf_cnt < 2'd2);

    // Assemble the tagged buffer word from the FIFO head and raster position
    always_comb begin
        // NOTE: default first so every bit is assigned on every path; no latch.
        pop_word                  = '0;
        pop_word[DATA_W-1:0]      = fifo_dout;
        pop_word[DATA_W+TAG_SOF]  = tag_sof;
        pop_word[DATA_W+TAG_EOL]  = tag_eol;
        pop_word[DATA_W+TAG_EOF]  = tag_eof;
    end

    stream_skid_buf #(
        .WIDTH (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fifo_rd_en),
        .in_data   (pop_word),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (buf_word),
        .cnt       (buf_cnt)
    );

    assign m_data     = buf_word[DATA_W-1:0];
    assign m_sof      = buf_word[DATA_W+TAG_SOF];
    assign m_eol      = buf_word[DATA_W+TAG_EOL];
    assign m_eof      = buf_word[DATA_W+TAG_EOF];
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DRAIN) && (buf_cnt == 2'd0);
    assign underrun_cnt = under_q;

    // Frame FSM and raster position; position advances once per pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q <= ST_STREAM;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (fifo_rd_en) begin
                        if (tag_eof) begin
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= ST_DRAIN;
                        end else if (tag_eol) begin
                            x_q <= '0;
                            y_q <= y_q + YW'(1);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (buf_cnt == 2'd0) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Saturating starvation counter, cleared when a new frame is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            under_q <= 16'd0;
        end else if ((state_q == ST_IDLE) && frame_start) begin
            under_q <= 16'd0;
        end else if (underrun_cycle && (under_q != 16'hFFFF)) begin
            under_q <= under_q + 16'd1;
        end
    end

endmodule
